// File: rtl/pcs_block_sync_if.sv
// pcs_block_sync_if -- block stream between the 66/64 RX gearbox, the
// block-sync stage and the descrambler for one 40GbE PCS lane.
//
// Signals:
//   in_valid / in_header[1:0] / in_data[63:0]  block from the gearbox
//   slip                                        one-bit realign request to the gearbox
//   block_lock                                  lane locked
//   out_valid / out_header[1:0] / out_data[63:0] block to the descrambler
//   hi_ber                                      high bit-error-rate flag
//
// Modports:
//   master : environment side (drives in_*, observes everything else)
//   slave  : pcs_block_sync side
interface pcs_block_sync_if;
  logic        in_valid;
  logic [1:0]  in_header;
  logic [63:0] in_data;
  logic        slip;
  logic        block_lock;
  logic        out_valid;
  logic [1:0]  out_header;
  logic [63:0] out_data;
  logic        hi_ber;

  modport master (
    output in_valid, in_header, in_data,
    input  slip, block_lock, out_valid, out_header, out_data, hi_ber
  );

  modport slave (
    input  in_valid, in_header, in_data,
    output slip, block_lock, out_valid, out_header, out_data, hi_ber
  );
endinterface

// File: rtl/pcs_block_sync.sv
// pcs_block_sync -- per-lane 64b/66b block synchronisation for the 40GbE
// PCS receive path. Tests the sync header of every block, runs the
// block-lock state machine, asks the gearbox for one-bit slips until lock
// is found and forwards header/payload (one cycle registered) once locked.
//
// Ports:
//   clk    in  core clock, single domain
//   reset  in  synchronous, active-high
//   bus    pcs_block_sync_if.slave (in_valid/in_header/in_data in;
//          slip/block_lock/out_valid/out_header/out_data/hi_ber out)
//
// Build option:
//   PCS_BLOCK_SYNC_HI_BER_EN  defined   -> high-BER monitor present
//                             undefined -> hi_ber tied to 0
module pcs_block_sync #(
  parameter int SH_CNT_LOCK    = 64,
  parameter int SH_INVALID_MAX = 16,
  parameter int SLIP_WAIT      = 8,
  parameter int HI_BER_WINDOW  = 1250,
  parameter int HI_BER_THRESH  = 16
) (
  input logic             clk,
  input logic             reset,
  pcs_block_sync_if.slave bus
);

  localparam int WAIT_W = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    ST_RESET_CNT = 2'd0,
    ST_TEST_SH   = 2'd1,
    ST_SLIP      = 2'd2,
    ST_SLIP_WAIT = 2'd3
  } state_t;

  // 01 and 10 are the only legal sync headers.
  function automatic logic sh_valid(input logic [1:0] hdr);
    return hdr[1] ^ hdr[0];
  endfunction

  state_t            state, state_nx;
  logic [6:0]        sh_cnt, sh_cnt_nx, sh_cnt_inc;
  logic [4:0]        sh_invalid_cnt, inv_nx, inv_inc;
  logic [WAIT_W-1:0] wait_cnt, wait_nx;
  logic              lock, lock_nx;
  logic              slip_pulse;
  logic              hdr_ok;
  logic              fwd_valid;
  logic [1:0]        fwd_header;
  logic [63:0]       fwd_data;
  logic              hi_ber_flag;

  // Next-state, counter and lock decisions for the block-lock machine.
  always_comb begin
    state_nx   = state;
    sh_cnt_nx  = sh_cnt;
    inv_nx     = sh_invalid_cnt;
    wait_nx    = wait_cnt;
    lock_nx    = lock;
    hdr_ok     = sh_valid(bus.in_header);
    sh_cnt_inc = sh_cnt + 7'd1;
    inv_inc    = sh_invalid_cnt + {4'd0, ~hdr_ok};
    case (state)
      ST_RESET_CNT: begin
        // No block is consumed here, even if one is presented.
        sh_cnt_nx = 7'd0;
        inv_nx    = 5'd0;
        state_nx  = ST_TEST_SH;
      end
      ST_TEST_SH: begin
        if (bus.in_valid) begin
          sh_cnt_nx = sh_cnt_inc;
          inv_nx    = inv_inc;
          if (!lock) begin
            if (!hdr_ok) begin
              state_nx = ST_SLIP;
            end else if (sh_cnt_inc == 7'(SH_CNT_LOCK) && inv_inc == 5'd0) begin
              lock_nx  = 1'b1;
              state_nx = ST_RESET_CNT;
            end else begin
              state_nx = ST_TEST_SH;
            end
          end else begin
            // Loss of lock is checked first so it wins on the window's last block.
            if (inv_inc == 5'(SH_INVALID_MAX)) begin
              lock_nx  = 1'b0;
              state_nx = ST_SLIP;
            end else if (sh_cnt_inc == 7'(SH_CNT_LOCK)) begin
              state_nx = ST_RESET_CNT;
            end else begin
              state_nx = ST_TEST_SH;
            end
          end
        end else begin
          state_nx = ST_TEST_SH;
        end
      end
      ST_SLIP: begin
        // Loaded with SLIP_WAIT-1 so the wait state lasts SLIP_WAIT cycles.
        lock_nx  = 1'b0;
        wait_nx  = WAIT_W'(SLIP_WAIT - 1);
        state_nx = ST_SLIP_WAIT;
      end
      ST_SLIP_WAIT: begin
        if (wait_cnt == {WAIT_W{1'b0}}) begin
          state_nx = ST_RESET_CNT;
        end else begin
          wait_nx  = wait_cnt - {{(WAIT_W-1){1'b0}}, 1'b1};
          state_nx = ST_SLIP_WAIT;
        end
      end
      default: begin
        state_nx = ST_RESET_CNT;
      end
    endcase
  end

  // State, counters, lock flag and the registered slip pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_RESET_CNT;
      sh_cnt         <= 7'd0;
      sh_invalid_cnt <= 5'd0;
      wait_cnt       <= {WAIT_W{1'b0}};
      lock           <= 1'b0;
      slip_pulse     <= 1'b0;
    end else begin
      state          <= state_nx;
      sh_cnt         <= sh_cnt_nx;
      sh_invalid_cnt <= inv_nx;
      wait_cnt       <= wait_nx;
      lock           <= lock_nx;
      slip_pulse     <= (state_nx == ST_SLIP);
    end
  end

  // Forwarding register; out_valid uses the lock value from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      fwd_valid  <= 1'b0;
      fwd_header <= 2'b00;
      fwd_data   <= 64'd0;
    end else begin
      fwd_valid <= bus.in_valid & lock;
      if (bus.in_valid) begin
        fwd_header <= bus.in_header;
        fwd_data   <= bus.in_data;
      end
    end
  end

`ifdef PCS_BLOCK_SYNC_HI_BER_EN
  localparam int WIN_W = $clog2(HI_BER_WINDOW);
  localparam int BER_W = $clog2(HI_BER_THRESH + 1);

  logic [WIN_W-1:0] win_cnt;
  logic [BER_W-1:0] ber_cnt, ber_sum;
  logic             ber_hit, win_end;

  // Invalid headers consumed by the lock machine, saturating at the threshold.
  always_comb begin
    ber_hit = (state == ST_TEST_SH) && bus.in_valid && !hdr_ok && lock;
    win_end = (win_cnt == WIN_W'(HI_BER_WINDOW - 1));
    if (ber_hit && (ber_cnt != BER_W'(HI_BER_THRESH))) begin
      ber_sum = ber_cnt + {{(BER_W-1){1'b0}}, 1'b1};
    end else begin
      ber_sum = ber_cnt;
    end
  end

  // Window counter and hi_ber flag; both held cleared while unlocked.
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt     <= {WIN_W{1'b0}};
      ber_cnt     <= {BER_W{1'b0}};
      hi_ber_flag <= 1'b0;
    end else if (!lock) begin
      win_cnt     <= {WIN_W{1'b0}};
      ber_cnt     <= {BER_W{1'b0}};
      hi_ber_flag <= 1'b0;
    end else if (win_end) begin
      // The window's verdict replaces the flag; the block on this cycle still counts.
      win_cnt     <= {WIN_W{1'b0}};
      ber_cnt     <= {BER_W{1'b0}};
      hi_ber_flag <= lock_nx && (ber_sum == BER_W'(HI_BER_THRESH));
    end else begin
      win_cnt     <= win_cnt + {{(WIN_W-1){1'b0}}, 1'b1};
      ber_cnt     <= ber_sum;
      hi_ber_flag <= lock_nx && (hi_ber_flag || (ber_sum == BER_W'(HI_BER_THRESH)));
    end
  end
`else
  assign hi_ber_flag = 1'b0;
`endif

  assign bus.slip       = slip_pulse;
  assign bus.block_lock = lock;
  assign bus.out_valid  = fwd_valid;
  assign bus.out_header = fwd_header;
  assign bus.out_data   = fwd_data;
  assign bus.hi_ber     = hi_ber_flag;

endmodule

// File: tb/tb_pcs_block_sync.sv
// tb_pcs_block_sync -- directed bench for pcs_block_sync. Each cycle pushes
// the expected forwarded block into a queue and pops it one edge later;
// lock, slip and hi_ber expectations come from the stimulus plan.
module tb_pcs_block_sync;

`ifdef PCS_BLOCK_SYNC_HI_BER_EN
  localparam bit HB_EN = 1'b1;
`else
  localparam bit HB_EN = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [1:0]  header;
    logic [63:0] data;
  } exp_t;

  logic clk;
  logic reset;
  pcs_block_sync_if bus();

  pcs_block_sync #(.HI_BER_WINDOW(200)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          slip_seen = 0;
  exp_t        exp_q[$];
  logic        exp_lock = 1'b0;
  logic [1:0]  last_h = 2'b00;
  logic [63:0] last_d = 64'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count slip pulses as seen at the active edge.
  always @(posedge clk) begin
    if (bus.slip === 1'b1) slip_seen <= slip_seen + 1;
  end

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_slip"},   64'(bus.slip),       64'd0);
    check({tag, "_lock"},   64'(bus.block_lock), 64'd0);
    check({tag, "_oval"},   64'(bus.out_valid),  64'd0);
    check({tag, "_ohdr"},   64'(bus.out_header), 64'd0);
    check({tag, "_odata"},  bus.out_data,        64'd0);
    check({tag, "_hi_ber"}, 64'(bus.hi_ber),     64'd0);
  endtask

  // One clock: drive a block, then check outputs #1 after the edge.
  task automatic cycle(input logic v, input logic [1:0] h, input logic [63:0] d,
                       input logic lock_after, input logic slip_after, input logic hb_after);
    exp_t e;
    bus.in_valid  = v;
    bus.in_header = h;
    bus.in_data   = d;
    if (v) begin
      last_h = h;
      last_d = d;
    end
    exp_q.push_back('{valid: v && exp_lock, header: last_h, data: last_d});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("out_valid",  64'(bus.out_valid),  64'(e.valid));
    check("out_header", 64'(bus.out_header), 64'(e.header));
    check("out_data",   bus.out_data,        e.data);
    check("block_lock", 64'(bus.block_lock), 64'(lock_after));
    check("slip",       64'(bus.slip),       64'(slip_after));
    check("hi_ber",     64'(bus.hi_ber),     64'(hb_after));
    exp_lock = lock_after;
  endtask

  initial begin
    logic bad;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_header = 2'b00;
    bus.in_data   = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;

    // Lock from reset: RESET_CNT cycle, then 64 good blocks.
    cycle(1'b0, 2'b00, rnd64(), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) cycle(1'b1, 2'b01, rnd64(), (i == 64), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b1, 2'b10, rnd64(), 1'b1, 1'b0, 1'b0);

    // One-cycle reset while locked and forwarding.
    bus.in_valid  = 1'b1;
    bus.in_header = 2'b01;
    bus.in_data   = rnd64();
    reset         = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_all_zero("midreset");
    exp_lock = 1'b0;
    last_h   = 2'b00;
    last_d   = 64'd0;

    // Relock: the block offered in RESET_CNT is not counted.
    cycle(1'b1, 2'b01, rnd64(), 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) cycle(1'b1, 2'b01, rnd64(), (i == 64), 1'b0, 1'b0);

    // Locked: 15 invalid in one window holds lock; 16 (last on block 64) drops it.
    cycle(1'b0, 2'b00, rnd64(), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      bad = (i % 4 == 0) && (i <= 60);
      cycle(1'b1, bad ? 2'b11 : 2'b01, rnd64(), 1'b1, 1'b0, 1'b0);
    end
    cycle(1'b0, 2'b00, rnd64(), 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 64; i++) begin
      bad = (i % 4 == 0);
      cycle(1'b1, bad ? 2'b11 : 2'b01, rnd64(), (i != 64), (i == 64),
            HB_EN && (i >= 4) && (i < 64));
    end
    // SLIP, 8 wait cycles and RESET_CNT ignore even invalid headers.
    for (int i = 0; i < 10; i++) cycle(1'b1, 2'b00, rnd64(), 1'b0, 1'b0, 1'b0);

    // Unlocked: header 00 on block 10 slips.
    for (int i = 1; i <= 10; i++)
      cycle(1'b1, (i == 10) ? 2'b00 : 2'b01, rnd64(), 1'b0, (i == 10), 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 2'b11, rnd64(), 1'b0, 1'b0, 1'b0);

    // in_valid toggling: lock on the 128th cycle.
    for (int i = 1; i <= 64; i++) begin
      cycle(1'b0, 2'b11, rnd64(), 1'b0, 1'b0, 1'b0);
      cycle(1'b1, 2'b01, rnd64(), (i == 64), 1'b0, 1'b0);
    end

    // High-BER: 8 invalid in each of two 64-block windows inside one 200-cycle window.
    for (int idx = 0; idx < 410; idx++) begin
      bad = ((idx >= 1) && (idx <= 64) && (idx % 8 == 0)) ||
            ((idx >= 66) && (idx <= 129) && ((idx - 65) % 8 == 0));
      cycle(1'b1, bad ? 2'b00 : 2'b10, rnd64(), 1'b1, 1'b0,
            HB_EN && (idx >= 129) && (idx < 399));
    end

    // Gap cycles while locked are not forwarded.
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 2'b10, rnd64(), 1'b1, 1'b0, 1'b0);
      cycle(1'b1, 2'b01, rnd64(), 1'b1, 1'b0, 1'b0);
    end

    check("slip_total", 64'(slip_seen), 64'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
